requant_clamp: RTL
==================

# requant_clamp

Multi-channel requantisation stage that turns accumulator-plus-bias words into narrow signed activations. It replaces the fixed 5-bit clamp with:
- a run-time arithmetic right shift with round-half-up,
- a run-time output bit-width clamp,
- an optional ReLU floor,
- valid/ready flow control.

It sits between the bias-add stage and the activation write-back buffer and processes CH channels per beat.

## Interface
- D_BW, 8, output word width per channel (signed)
- AB_BW, 21, input accumulator+bias width per channel (signed)
- CH, 4, channels processed in parallel per beat
- SH_BW, 5, width of shift control; legal shift 0..AB_BW-1
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept input this cycle
- i_acc_bias  in  CH*AB_BW  channel c at bits [c*AB_BW +: AB_BW], signed
- i_shift  in  SH_BW  right-shift amount, sampled with the beat
- i_out_bits  in  4  effective output width b, sampled with the beat
- i_relu  in  1  1 = lower clamp bound is 0, sampled with the beat
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts output
- o_data  out  CH*D_BW  channel c at bits [c*D_BW +: D_BW], signed
- o_sat_flags  out  CH  per-channel "value was clamped" for the current output beat
- i_sat_clr  in  1  synchronous clear of o_sat_cnt (REQUANT_SAT_CNT_EN only)
- o_sat_cnt  out  16  saturation event counter (REQUANT_SAT_CNT_EN only)

## Operation
- **Stage 1 (shift/round), per channel:**
  - Sign-extend x to AB_BW+1.
  - If s>0: y = (x + 2^(s-1)) >>> s. If s=0: y = x.
  - This gives round-half-up (toward +inf on ties): 6,s=2 -> 2; -6,s=2 -> -1; -2,s=2 -> 0.
  - Register y together with b and relu.
- **Shift legalisation:** if i_shift >= AB_BW, the shift is treated as AB_BW-1.
- **Stage 2 (clamp), per channel:**
  - Legalise b: b<2 -> 2, b>D_BW -> D_BW.
  - Bounds: MAX = 2^(b-1)-1; MIN = relu ? 0 : -2^(b-1).
  - Clamp: y<MIN -> MIN; y>MAX -> MAX; else y.
  - Sign-extend the result to D_BW.
  - Set the sat flag for channel c when clamping occurred.
  - ReLU flooring a negative value to 0 counts as saturation.
- **Parameters:** all channels share shift/b/relu for a beat. Parameters may change every beat with no bubble.
- **Handshake (two-stage elastic pipeline):**
  - s2_adv = !s2_v | i_ready
  - s1_adv = !s1_v | s2_adv
  - o_ready = s1_adv, which is combinational from i_ready.
  - Input transfers on i_valid & o_ready.
  - Output transfers on o_valid & i_ready.
- **Data stability:** o_valid, o_data and o_sat_flags stay stable while o_valid & !i_ready. No beat is dropped or duplicated, and order is preserved.
- **Reset:** s1_v, s2_v, o_valid, o_data, o_sat_flags and o_sat_cnt all go to 0. Reset mid-stream discards in-flight beats.

## Timing
- Latency is 2 cycles: a beat accepted at edge n is presented on o_valid after edge n+1 and can be consumed at edge n+2.
- Throughput is 1 beat/cycle with i_ready held high.
- With i_ready low, the block accepts at most 2 beats, then o_ready falls in the same cycle.
- When i_ready rises, o_ready rises in the same cycle, so there is no extra bubble.
- o_data and o_sat_flags are registered outputs. o_ready is the only combinational output.

## Configuration
- REQUANT_SAT_CNT_EN defined:
  - o_sat_cnt increments by popcount(o_sat_flags) on each output transfer.
  - It saturates at 16'hFFFF.
  - i_sat_clr zeroes it; clear wins over a simultaneous increment.
- REQUANT_SAT_CNT_EN undefined:
  - No counter logic is built.
  - o_sat_cnt is tied to 0 and i_sat_clr is ignored.
  - Both ports remain present.

## Structure
- Package requant_pkg holds:
  - the OUT_BITS_W=4 constant,
  - the SAT_CNT_W=16 constant,
  - a function returning {min,max} for a given (b, relu, D_BW).
- Sub-module requant_lane: one channel's round/shift and clamp datapath, combinational.
  - The top instantiates CH lanes.
  - The top owns the pipeline registers, the handshake and the counter.

## Test plan
- **Clamp, no shift.** b=5, s=0, relu=0, inputs {-100,7,200,-16} -> o_data {-16,7,15,-16}, sat_flags 4'b0101, valid 2 cycles after accept.
- **Rounding.** b=8, s=2, inputs {6,-6,-2,1023} -> {2,-1,0,127}, sat_flags 4'b1000.
- **ReLU and legalisation.** relu=1, b=5, s=0, {-5,20,3,0} -> {0,15,3,0}. Repeating with b=1 and with b=15 clamps as b=2 and b=8 respectively.
- **Backpressure.** Stream 6 beats with i_ready low for cycles 2-4. Expect o_ready low once 2 beats are held, all 6 outputs in order, o_data stable while stalled.
- **Reset mid-stream.** Assert rst_n low with 2 beats in flight. Expect o_valid=0 and o_data=0 immediately, and no stale beat after release.
- **Counter (macro on).** 3 beats, each with 2 saturated channels -> o_sat_cnt=6. i_sat_clr concurrent with a saturating transfer -> 0. Preloaded 16'hFFFE plus 4 saturations -> 16'hFFFF.

Source files
------------

// File: rtl/requant_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : requant_pkg
//  Description : Shared constants and clamp-bound helper for requant_clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package requant_pkg;

  localparam int OUT_BITS_W = 4;
  localparam int SAT_CNT_W  = 16;

  // Clamp bounds, packed as {min, max}.
  typedef struct packed {
    logic signed [31:0] min_v;
    logic signed [31:0] max_v;
  } bounds_t;

  // Legalise the effective width to 2..d_bw, then derive the signed range.
  // With relu set the lower bound is raised to zero.
  function automatic bounds_t clamp_bounds(input logic [OUT_BITS_W-1:0] b,
                                           input logic                  relu,
                                           input int                    d_bw);
    int      bl;
    bounds_t r;
    bl = int'(b);
    if (bl < 2) begin
      bl = 2;
    end else if (bl > d_bw) begin
      bl = d_bw;
    end
    r.max_v = (32'sd1 <<< (bl - 1)) - 32'sd1;
    r.min_v = relu ? 32'sd0 : -(32'sd1 <<< (bl - 1));
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/requant_lane.sv
`default_nettype none
// ============================================================================
//  Module      : requant_lane
//  Description : One channel of the requantiser, purely combinational.
//                Front half: arithmetic right shift with round-half-up.
//                Back half : clamp of a registered shifted value to the
//                            run-time output width, with optional ReLU floor.
//                The two halves are separated by pipeline registers that
//                live in the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module requant_lane
  import requant_pkg::*;
#(
  parameter int D_BW  = 8,
  parameter int AB_BW = 21,
  parameter int SH_BW = 5
) (
  input  logic signed [AB_BW-1:0]      x_i,
  input  logic        [SH_BW-1:0]      shift_i,
  output logic signed [AB_BW:0]        y_o,
  input  logic signed [AB_BW:0]        y_i,
  input  logic        [OUT_BITS_W-1:0] out_bits_i,
  input  logic                         relu_i,
  output logic        [D_BW-1:0]       data_o,
  output logic                         sat_o
);

  logic signed [AB_BW:0] w_x_ext;
  logic        [AB_BW:0] w_half;
  logic signed [AB_BW:0] w_sum;
  bounds_t               w_b;
  logic signed [31:0]    w_y32;

  // Shift/round: adding half an LSB before the arithmetic shift rounds ties
  // toward +inf. One extra bit of headroom keeps the add from overflowing.
  always_comb begin
    w_x_ext = {x_i[AB_BW-1], x_i};
    w_half  = '0;
    if (shift_i != '0) begin
      w_half = (AB_BW+1)'(1) << (shift_i - SH_BW'(1));
    end
    w_sum = w_x_ext + $signed(w_half);
    y_o   = w_sum >>> shift_i;
  end

  // Clamp to [min, max] for the legalised width; any clamp sets the flag.
  always_comb begin
    w_b    = clamp_bounds(out_bits_i, relu_i, D_BW);
    w_y32  = {{(31-AB_BW){y_i[AB_BW]}}, y_i};
    data_o = y_i[D_BW-1:0];
    sat_o  = 1'b0;
    if (w_y32 < $signed(w_b.min_v)) begin
      data_o = w_b.min_v[D_BW-1:0];
      sat_o  = 1'b1;
    end else if (w_y32 > $signed(w_b.max_v)) begin
      data_o = w_b.max_v[D_BW-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/requant_clamp.sv
`default_nettype none
// ============================================================================
//  Module      : requant_clamp
//  Description : CH-channel requantiser: shift/round, width clamp, optional
//                ReLU floor, behind a two-stage elastic valid/ready pipeline.
//                Optional feature macro: REQUANT_SAT_CNT_EN builds a
//                saturating 16-bit counter of clamped channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module requant_clamp
  import requant_pkg::*;
#(
  parameter int D_BW  = 8,
  parameter int AB_BW = 21,
  parameter int CH    = 4,
  parameter int SH_BW = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [CH*AB_BW-1:0]    i_acc_bias,
  input  logic [SH_BW-1:0]       i_shift,
  input  logic [OUT_BITS_W-1:0]  i_out_bits,
  input  logic                   i_relu,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [CH*D_BW-1:0]     o_data,
  output logic [CH-1:0]          o_sat_flags,
  input  logic                   i_sat_clr,
  output logic [SAT_CNT_W-1:0]   o_sat_cnt
);

  localparam int YW = AB_BW + 1;

  logic                   w_s1_adv;
  logic                   w_s2_adv;
  logic [SH_BW-1:0]       w_shift;
  logic [CH*YW-1:0]       w_y;
  logic [CH*D_BW-1:0]     w_data;
  logic [CH-1:0]          w_sat;

  logic                   s1_v_q;
  logic [CH*YW-1:0]       s1_y_q;
  logic [OUT_BITS_W-1:0]  s1_bits_q;
  logic                   s1_relu_q;
  logic                   s2_v_q;
  logic [CH*D_BW-1:0]     s2_data_q;
  logic [CH-1:0]          s2_sat_q;

  // Out-of-range shifts collapse to the widest legal shift.
  assign w_shift  = (i_shift >= SH_BW'(AB_BW)) ? SH_BW'(AB_BW-1) : i_shift;

  assign w_s2_adv = !s2_v_q || i_ready;
  assign w_s1_adv = !s1_v_q || w_s2_adv;
  assign o_ready  = w_s1_adv;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    requant_lane #(
      .D_BW  (D_BW),
      .AB_BW (AB_BW),
      .SH_BW (SH_BW)
    ) u_lane (
      .x_i        (i_acc_bias[c*AB_BW +: AB_BW]),
      .shift_i    (w_shift),
      .y_o        (w_y[c*YW +: YW]),
      .y_i        (s1_y_q[c*YW +: YW]),
      .out_bits_i (s1_bits_q),
      .relu_i     (s1_relu_q),
      .data_o     (w_data[c*D_BW +: D_BW]),
      .sat_o      (w_sat[c])
    );
  end

  // Stage 1: capture shifted values with the beat's width/ReLU controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_y_q    <= '0;
      s1_bits_q <= '0;
      s1_relu_q <= 1'b0;
    end else if (w_s1_adv) begin
      s1_v_q <= i_valid;
      if (i_valid) begin
        s1_y_q    <= w_y;
        s1_bits_q <= i_out_bits;
        s1_relu_q <= i_relu;
      end
    end
  end

  // Stage 2: registered clamp results; held unchanged while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_sat_q  <= '0;
    end else if (w_s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_data_q <= w_data;
        s2_sat_q  <= w_sat;
      end
    end
  end

  assign o_valid     = s2_v_q;
  assign o_data      = s2_data_q;
  assign o_sat_flags = s2_sat_q;

`ifdef REQUANT_SAT_CNT_EN
  logic [SAT_CNT_W-1:0] sat_cnt_q;
  logic [SAT_CNT_W-1:0] sat_cnt_d;
  logic [SAT_CNT_W:0]   w_pop;
  logic [SAT_CNT_W:0]   w_cnt_sum;

  // Next count: clear dominates; otherwise add this transfer's clamps, capped.
  always_comb begin
    w_pop = '0;
    for (int c = 0; c < CH; c++) begin
      w_pop = w_pop + {{SAT_CNT_W{1'b0}}, s2_sat_q[c]};
    end
    w_cnt_sum = {1'b0, sat_cnt_q} + w_pop;
    sat_cnt_d = sat_cnt_q;
    if (i_sat_clr) begin
      sat_cnt_d = '0;
    end else if (s2_v_q && i_ready) begin
      sat_cnt_d = w_cnt_sum[SAT_CNT_W] ? '1 : w_cnt_sum[SAT_CNT_W-1:0];
    end
  end

  // Saturation event counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign o_sat_cnt = sat_cnt_q;
`else
  logic w_unused_sat_clr;
  assign w_unused_sat_clr = i_sat_clr;
  assign o_sat_cnt        = '0;
`endif

endmodule
`default_nettype wire
